// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               fetch FSM state encoding, the NOP word loaded on reset and
//               the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    FAULT = 2'd2
  } if_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] c_NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Purely combinational branch-resolution and next-PC selection
//               for the instruction currently held by the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1_data,
  input  logic        i_branch,
  input  logic        i_nbranch,
  input  logic        i_branch_lt,
  input  logic        i_branch_ge,
  input  logic        i_branch_ltu,
  input  logic        i_branch_geu,
  input  logic        i_jal,
  input  logic        i_jalr,
  input  logic        i_zero,
  input  logic        i_lt,
  input  logic        i_ltu,
  output logic        o_taken,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_jalr_sum;

  assign w_jalr_sum = i_rs1_data + i_imm;

  // Resolve the conditional branch, then pick the target by priority:
  // jalr over jal over taken branch over sequential. All sums wrap mod 2^32.
  always_comb begin
    o_taken = (i_branch     &  i_zero) |
              (i_nbranch    & ~i_zero) |
              (i_branch_lt  &  i_lt)   |
              (i_branch_ge  & ~i_lt)   |
              (i_branch_ltu &  i_ltu)  |
              (i_branch_geu & ~i_ltu);
    o_next_pc = i_pc + 32'd4;
    if (i_jalr) begin
      o_next_pc = {w_jalr_sum[31:1], 1'b0};
    end else if (i_jal || o_taken) begin
      o_next_pc = i_pc + i_imm;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Single-outstanding instruction fetch unit. Requests the word
//               at pc, holds it for the decoder until it retires, then
//               advances pc via next_pc_calc. Memory timeouts and misaligned
//               targets park the unit in a sticky fault until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = c_RESET_PC_DEFAULT,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        branch_lt,
  input  logic        branch_ge,
  input  logic        branch_ltu,
  input  logic        branch_geu,
  input  logic        jal,
  input  logic        jalr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic        fault
);

  localparam int CW = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(IMEM_TIMEOUT - 1);

  if_state_t   r_state;
  if_state_t   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_insn;
  logic [CW-1:0] r_cnt;
  logic [31:0] w_next_pc;
  logic        w_taken;

  next_pc_calc u_next_pc_calc (
    .i_pc         (r_pc),
    .i_imm        (imm),
    .i_rs1_data   (rs1_data),
    .i_branch     (Branch),
    .i_nbranch    (nBranch),
    .i_branch_lt  (branch_lt),
    .i_branch_ge  (branch_ge),
    .i_branch_ltu (branch_ltu),
    .i_branch_geu (branch_geu),
    .i_jal        (jal),
    .i_jalr       (jalr),
    .i_zero       (zero),
    .i_lt         (lt),
    .i_ltu        (ltu),
    .o_taken      (w_taken),
    .o_next_pc    (w_next_pc)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs. The request is masked during reset so no
  // fetch is advertised until the first cycle after release.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    inst_valid  = 1'b0;
    fault       = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_state_nxt = ISSUE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = FAULT;
        end
      end
      ISSUE: begin
        inst_valid = 1'b1;
        if (exec_done) begin
          // A halfword-misaligned target can never be fetched: fault instead.
          w_state_nxt = w_next_pc[1] ? FAULT : FETCH;
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        w_state_nxt = FAULT;
      end
    endcase
    if (rst) begin
      imem_req = 1'b0;
    end
  end

  // PC, held instruction and ack-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_insn <= c_NOP_INSN;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_insn <= imem_rdata;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ISSUE: begin
          if (exec_done && !w_next_pc[1]) begin
            r_pc <= w_next_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign instruction = r_insn;

endmodule
`default_nettype wire
